tcu_uop_sequencer: RTL and testbench

- Sits directly upstream of the tensor-core execute stage.
- Accepts one matrix-multiply-accumulate instruction header plus its tile step counts.
- Expands it into a serial stream of micro-ops, one per (step_k, step_m, step_n) triple. Each micro-op carries the step indices, the format fields, and a first/last marker.
- The downstream core consumes one micro-op per execute handshake. Order: step_n fastest, then step_m, then step_k slowest.

---
 rtl/tcu_uop_sequencer.sv | 166 ++++++++++++++++
 tb/tb_tcu_uop_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcu_uop_sequencer.sv
// Purpose: expands one tensor-core MMA instruction into a (k,m,n) micro-op stream, n fastest, k slowest.
// Latency: first micro-op is valid the cycle after the instruction is accepted, then one per cycle.
// Backpressure: out_ready low freezes outputs and counters; in_ready rises only in IDLE or on the final out handshake.
module tcu_uop_sequencer #(
    parameter int NW_BITS   = 4,
    parameter int UUID_BITS = 44,
    parameter int NT        = 4,
    parameter int NR_BITS   = 5,
    parameter int STEP_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [UUID_BITS-1:0] in_uuid,
    input  logic [NW_BITS-1:0]   in_wid,
    input  logic [NT-1:0]        in_tmask,
    input  logic [NR_BITS-1:0]   in_rd,
    input  logic [3:0]           in_fmt_s,
    input  logic [3:0]           in_fmt_d,
    input  logic [STEP_W-1:0]    in_cnt_m,
    input  logic [STEP_W-1:0]    in_cnt_n,
    input  logic [STEP_W-1:0]    in_cnt_k,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [UUID_BITS-1:0] out_uuid,
    output logic [NW_BITS-1:0]   out_wid,
    output logic [NT-1:0]        out_tmask,
    output logic [NR_BITS-1:0]   out_rd,
    output logic [3:0]           out_fmt_s,
    output logic [3:0]           out_fmt_d,
    output logic [STEP_W-1:0]    out_step_m,
    output logic [STEP_W-1:0]    out_step_n,
    output logic [STEP_W-1:0]    out_step_k,
    output logic                 out_acc_init,
    output logic                 out_first,
    output logic                 out_last,
    output logic                 busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Header fields carried unchanged on every micro-op of an instruction.
    typedef struct packed {
        logic [UUID_BITS-1:0] uuid;
        logic [NW_BITS-1:0]   wid;
        logic [NT-1:0]        tmask;
        logic [NR_BITS-1:0]   rd;
        logic [3:0]           fmt_s;
        logic [3:0]           fmt_d;
    } hdr_t;

    state_t             state_q, state_d;
    hdr_t               hdr_q;
    logic [STEP_W-1:0]  cnt_m_q, cnt_n_q, cnt_k_q;
    logic [STEP_W-1:0]  step_m_q, step_n_q, step_k_q;
    logic               out_fire;
    logic               load;
    logic               advance;

    assign out_valid = (state_q == ISSUE);
    assign busy      = (state_q == ISSUE);
    assign out_fire  = out_valid && out_ready;

    assign out_uuid   = hdr_q.uuid;
    assign out_wid    = hdr_q.wid;
    assign out_tmask  = hdr_q.tmask;
    assign out_rd     = hdr_q.rd;
    assign out_fmt_s  = hdr_q.fmt_s;
    assign out_fmt_d  = hdr_q.fmt_d;
    assign out_step_m = step_m_q;
    assign out_step_n = step_n_q;
    assign out_step_k = step_k_q;

    // Flags are pure functions of the registered counters, so no in_* to out_* path exists.
    assign out_first    = (step_m_q == '0) && (step_n_q == '0) && (step_k_q == '0);
    assign out_last     = (step_n_q == cnt_n_q) && (step_m_q == cnt_m_q) && (step_k_q == cnt_k_q);
    assign out_acc_init = (step_k_q == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, accept and step-advance decisions; in_ready may rise on the final handshake for zero-bubble chaining.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        advance  = 1'b0;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (out_fire) begin
                    if (out_last) begin
                        in_ready = 1'b1;
                        if (in_valid) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Header latch and nested step counters; the last micro-op never advances, so all-ones counts cannot wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_q    <= '0;
            cnt_m_q  <= '0;
            cnt_n_q  <= '0;
            cnt_k_q  <= '0;
            step_m_q <= '0;
            step_n_q <= '0;
            step_k_q <= '0;
        end else if (load) begin
            hdr_q    <= '{uuid: in_uuid, wid: in_wid, tmask: in_tmask, rd: in_rd,
                          fmt_s: in_fmt_s, fmt_d: in_fmt_d};
            cnt_m_q  <= in_cnt_m;
            cnt_n_q  <= in_cnt_n;
            cnt_k_q  <= in_cnt_k;
            step_m_q <= '0;
            step_n_q <= '0;
            step_k_q <= '0;
        end else if (advance) begin
            if (step_n_q < cnt_n_q) begin
                step_n_q <= step_n_q + STEP_W'(1);
            end else begin
                step_n_q <= '0;
                if (step_m_q < cnt_m_q) begin
                    step_m_q <= step_m_q + STEP_W'(1);
                end else begin
                    step_m_q <= '0;
                    step_k_q <= step_k_q + STEP_W'(1);
                end
            end
        end
    end

    // A stalled micro-op must be held unchanged until the execute stage takes it.
    assert property (@(posedge clk) disable iff (reset)
        out_valid && !out_ready |=> out_valid && $stable({hdr_q, step_m_q, step_n_q, step_k_q}));

    // A new instruction may only be taken while busy on the final micro-op handshake.
    assert property (@(posedge clk) disable iff (reset)
        in_valid && in_ready && busy |-> out_fire && out_last);

endmodule

// File: tb/tb_tcu_uop_sequencer.sv
// Bench for tcu_uop_sequencer: table of instructions with hand-computed micro-op counts,
// a queue-based expansion model checked every cycle, and hand sequences for chaining and reset.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_tcu_uop_sequencer;
    localparam int NW_BITS   = 4;
    localparam int UUID_BITS = 44;
    localparam int NT        = 4;
    localparam int NR_BITS   = 5;
    localparam int STEP_W    = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [UUID_BITS-1:0] in_uuid = '0;
    logic [NW_BITS-1:0]   in_wid = '0;
    logic [NT-1:0]        in_tmask = '0;
    logic [NR_BITS-1:0]   in_rd = '0;
    logic [3:0]           in_fmt_s = '0;
    logic [3:0]           in_fmt_d = '0;
    logic [STEP_W-1:0]    in_cnt_m = '0;
    logic [STEP_W-1:0]    in_cnt_n = '0;
    logic [STEP_W-1:0]    in_cnt_k = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [UUID_BITS-1:0] out_uuid;
    logic [NW_BITS-1:0]   out_wid;
    logic [NT-1:0]        out_tmask;
    logic [NR_BITS-1:0]   out_rd;
    logic [3:0]           out_fmt_s;
    logic [3:0]           out_fmt_d;
    logic [STEP_W-1:0]    out_step_m;
    logic [STEP_W-1:0]    out_step_n;
    logic [STEP_W-1:0]    out_step_k;
    logic                 out_acc_init;
    logic                 out_first;
    logic                 out_last;
    logic                 busy;

    always #5 clk = ~clk;

    tcu_uop_sequencer #(
        .NW_BITS(NW_BITS), .UUID_BITS(UUID_BITS), .NT(NT), .NR_BITS(NR_BITS), .STEP_W(STEP_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_uuid(in_uuid), .in_wid(in_wid), .in_tmask(in_tmask), .in_rd(in_rd),
        .in_fmt_s(in_fmt_s), .in_fmt_d(in_fmt_d),
        .in_cnt_m(in_cnt_m), .in_cnt_n(in_cnt_n), .in_cnt_k(in_cnt_k),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_uuid(out_uuid), .out_wid(out_wid), .out_tmask(out_tmask), .out_rd(out_rd),
        .out_fmt_s(out_fmt_s), .out_fmt_d(out_fmt_d),
        .out_step_m(out_step_m), .out_step_n(out_step_n), .out_step_k(out_step_k),
        .out_acc_init(out_acc_init), .out_first(out_first), .out_last(out_last),
        .busy(busy)
    );

    typedef struct packed {
        logic [UUID_BITS-1:0] uuid;
        logic [NW_BITS-1:0]   wid;
        logic [NT-1:0]        tmask;
        logic [NR_BITS-1:0]   rd;
        logic [3:0]           fmt_s;
        logic [3:0]           fmt_d;
        logic [STEP_W-1:0]    k;
        logic [STEP_W-1:0]    m;
        logic [STEP_W-1:0]    n;
        logic                 first;
        logic                 last;
        logic                 acc;
    } uop_t;

    typedef struct {
        logic [STEP_W-1:0] cm;
        logic [STEP_W-1:0] cn;
        logic [STEP_W-1:0] ck;
        int                rmode;
        int                exp_uops;
    } vec_t;

    uop_t obs;
    assign obs = {out_uuid, out_wid, out_tmask, out_rd, out_fmt_s, out_fmt_d,
                  out_step_k, out_step_m, out_step_n, out_first, out_last, out_acc_init};

    uop_t exp_q[$];
    uop_t hold;
    logic stalled = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   fires = 0;
    int   ready_mode = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the accepted instruction becomes an ordered list of micro-ops.
    task automatic expand();
        int   total;
        int   idx;
        uop_t u;
        total = (int'(in_cnt_m) + 1) * (int'(in_cnt_n) + 1) * (int'(in_cnt_k) + 1);
        idx = 0;
        for (int k = 0; k <= int'(in_cnt_k); k++)
            for (int m = 0; m <= int'(in_cnt_m); m++)
                for (int n = 0; n <= int'(in_cnt_n); n++) begin
                    u.uuid  = in_uuid;
                    u.wid   = in_wid;
                    u.tmask = in_tmask;
                    u.rd    = in_rd;
                    u.fmt_s = in_fmt_s;
                    u.fmt_d = in_fmt_d;
                    u.k     = STEP_W'(k);
                    u.m     = STEP_W'(m);
                    u.n     = STEP_W'(n);
                    u.first = (idx == 0);
                    u.last  = (idx == total - 1);
                    u.acc   = (k == 0);
                    exp_q.push_back(u);
                    idx++;
                end
    endtask

    // Downstream ready pattern.
    always @(posedge clk) begin
        #1;
        out_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
    end

    // Per-cycle monitor against the pending micro-op queue.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            stalled = 1'b0;
        end else begin
            chk("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
            chk("busy", 128'(busy), 128'(exp_q.size() > 0));
            chk("in_ready", 128'(in_ready),
                128'((exp_q.size() == 0) || (exp_q.size() == 1 && out_ready)));
            if (stalled) chk("stall_hold", 128'(obs), 128'(hold));
            if (out_valid && out_ready) begin
                fires++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_uop: got uop %h expected none", obs);
                end else begin
                    chk("uop", 128'(obs), 128'(exp_q.pop_front()));
                end
            end
            stalled = out_valid && !out_ready;
            hold = obs;
            if (in_valid && in_ready) expand();
        end
    end

    task automatic send(input logic [UUID_BITS-1:0] uuid, input logic [STEP_W-1:0] cm,
                        input logic [STEP_W-1:0] cn, input logic [STEP_W-1:0] ck);
        int c;
        in_valid = 1'b1;
        in_uuid  = uuid;
        in_wid   = NW_BITS'($urandom);
        in_tmask = NT'($urandom);
        in_rd    = NR_BITS'($urandom);
        in_fmt_s = 4'($urandom);
        in_fmt_d = 4'($urandom);
        in_cnt_m = cm;
        in_cnt_n = cn;
        in_cnt_k = ck;
        c = 0;
        while (c < 20000) begin
            @(negedge clk);
            if (in_ready) break;
            c++;
        end
        if (c >= 20000) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", c);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        checks++;
        if (c >= budget) begin
            errors++;
            $display("FAIL %s: %0d micro-ops still pending after %0d cycles, required 0", name, exp_q.size(), c);
        end
    endtask

    vec_t vecs[6];

    initial begin
        int f0;
        vecs[0] = '{cm: 4'd1,  cn: 4'd1,  ck: 4'd0,  rmode: 0, exp_uops: 4};
        vecs[1] = '{cm: 4'd0,  cn: 4'd1,  ck: 4'd2,  rmode: 0, exp_uops: 6};
        vecs[2] = '{cm: 4'd0,  cn: 4'd0,  ck: 4'd0,  rmode: 0, exp_uops: 1};
        vecs[3] = '{cm: 4'd3,  cn: 4'd3,  ck: 4'd3,  rmode: 1, exp_uops: 64};
        vecs[4] = '{cm: 4'd2,  cn: 4'd0,  ck: 4'd1,  rmode: 1, exp_uops: 6};
        vecs[5] = '{cm: 4'd15, cn: 4'd15, ck: 4'd15, rmode: 0, exp_uops: 4096};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_in_ready", 128'(in_ready), 128'(1));
        chk("reset_busy", 128'(busy), 128'(0));
        @(posedge clk);
        #1;

        // Table of single instructions with hand-computed micro-op counts.
        for (int i = 0; i < 6; i++) begin
            ready_mode = vecs[i].rmode;
            f0 = fires;
            send(UUID_BITS'(64'h100 + i), vecs[i].cm, vecs[i].cn, vecs[i].ck);
            wait_idle("table_drain", 20000);
            chk("uop_count", 128'(fires - f0), 128'(vecs[i].exp_uops));
        end
        @(negedge clk);
        chk("idle_after_max", 128'(busy), 128'(0));
        @(posedge clk);
        #1;

        // Back-to-back: second instruction accepted on the first's last handshake.
        ready_mode = 0;
        send(UUID_BITS'(64'hA1), 4'd0, 4'd0, 4'd1);
        send(UUID_BITS'(64'hB2), 4'd0, 4'd1, 4'd0);
        @(negedge clk);
        chk("b2b_first", 128'(out_first), 128'(1));
        chk("b2b_uuid", 128'(out_uuid), 128'(64'hB2));
        chk("b2b_valid", 128'(out_valid), 128'(1));
        @(posedge clk);
        #1;
        wait_idle("b2b_drain", 100);

        // Reset after the 5th micro-op of a 16-op instruction.
        f0 = fires;
        send(UUID_BITS'(64'hC3), 4'd0, 4'd3, 4'd3);
        for (int c = 0; c < 100 && fires < f0 + 5; c++) begin
            @(posedge clk);
            #1;
        end
        chk("pre_reset_fires", 128'(fires - f0), 128'(5));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_out_valid", 128'(out_valid), 128'(0));
        chk("midreset_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        send(UUID_BITS'(64'hD4), 4'd1, 4'd0, 4'd0);
        @(negedge clk);
        chk("restart_first", 128'(out_first), 128'(1));
        chk("restart_steps", 128'({out_step_k, out_step_m, out_step_n}), 128'(0));
        @(posedge clk);
        #1;
        wait_idle("restart_drain", 100);

        // Random instructions, random backpressure, sometimes queued while busy.
        for (int i = 0; i < 12; i++) begin
            ready_mode = int'($urandom_range(0, 1));
            send(UUID_BITS'({$urandom, $urandom}), STEP_W'($urandom_range(0, 3)),
                 STEP_W'($urandom_range(0, 3)), STEP_W'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) wait_idle("rand_drain", 2000);
        end
        wait_idle("final_drain", 2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
